cache_conj_ass_nvias: RTL and testbench

//  Parametrised N-way set-associative write-back, write-allocate data cache with true-LRU replacement.

---
 rtl/cache_conj_ass_nvias.sv | 205 ++++++++++++++++++++
 tb/tb_cache_conj_ass_nvias.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_conj_ass_nvias.sv
// N-way set-associative write-back/write-allocate cache with true-LRU, one word per line.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_conj_ass_nvias #(
    parameter int NUM_SETS = 2,
    parameter int NUM_WAYS = 2,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              hit,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
`ifdef CACHE_STATS_EN
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count,
`endif
    output logic [1:0]        state_dbg
);

    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int AGE_W   = $clog2(NUM_WAYS);
    localparam int TAG_W   = ADDR_W - INDEX_W;

    typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2, RESP = 2'd3} state_t;

    state_t state;

    logic [NUM_WAYS-1:0] valid_arr [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_arr [NUM_SETS];
    logic [AGE_W-1:0]    age_arr   [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_arr   [NUM_SETS][NUM_WAYS];
    logic [DATA_W-1:0]   data_arr  [NUM_SETS][NUM_WAYS];

    logic [INDEX_W-1:0] idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic [AGE_W-1:0]   way_q;
    logic               write_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               hit_q;

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               lk_hit;
    logic               lk_inv;
    logic [AGE_W-1:0]   lk_hit_way;
    logic [AGE_W-1:0]   lk_inv_way;
    logic [AGE_W-1:0]   lk_lru_way;
    logic [AGE_W-1:0]   lk_vic_way;
    logic [AGE_W-1:0]   lk_way;
    logic               lk_vic_dirty;

    assign req_idx   = cpu_addr[INDEX_W-1:0];
    assign req_tag   = cpu_addr[ADDR_W-1:INDEX_W];
    assign state_dbg = state;

    // Scan runs from the top way down so the lowest-index match or invalid way wins.
    always_comb begin
        lk_hit     = 1'b0;
        lk_inv     = 1'b0;
        lk_hit_way = '0;
        lk_inv_way = '0;
        lk_lru_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_arr[req_idx][w] && (tag_arr[req_idx][w] == req_tag)) begin
                lk_hit     = 1'b1;
                lk_hit_way = AGE_W'(w);
            end
            if (!valid_arr[req_idx][w]) begin
                lk_inv     = 1'b1;
                lk_inv_way = AGE_W'(w);
            end
            if (age_arr[req_idx][w] == AGE_W'(NUM_WAYS - 1)) begin
                lk_lru_way = AGE_W'(w);
            end
        end
        lk_vic_way   = lk_inv ? lk_inv_way : lk_lru_way;
        lk_way       = lk_hit ? lk_hit_way : lk_vic_way;
        lk_vic_dirty = valid_arr[req_idx][lk_vic_way] && dirty_arr[req_idx][lk_vic_way];
    end

    // Memory handshake: a request (mem_rd_req/mem_wr_req) is held with stable address/data
    // until mem_ack is seen at a rising edge; it drops the following cycle, and mem_ack is
    // ignored when neither request is high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            hit        <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            idx_q      <= '0;
            tag_q      <= '0;
            way_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            hit_q      <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_arr[s][w]  <= AGE_W'(w);
                    tag_arr[s][w]  <= '0;
                    data_arr[s][w] <= '0;
                end
            end
`ifdef CACHE_STATS_EN
            hit_count  <= '0;
            miss_count <= '0;
`endif
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        idx_q   <= req_idx;
                        tag_q   <= req_tag;
                        way_q   <= lk_way;
                        write_q <= cpu_write;
                        wdata_q <= cpu_wdata;
                        hit_q   <= lk_hit;
                        if (lk_hit) begin
                            state <= RESP;
                        end else if (lk_vic_dirty) begin
                            state      <= WB;
                            mem_wr_req <= 1'b1;
                            mem_addr   <= {tag_arr[req_idx][lk_vic_way], req_idx};
                            mem_wdata  <= data_arr[req_idx][lk_vic_way];
                        end else if (!cpu_write) begin
                            state      <= FILL;
                            mem_rd_req <= 1'b1;
                            mem_addr   <= cpu_addr;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        mem_wr_req <= 1'b0;
                        if (write_q) begin
                            state <= RESP;
                        end else begin
                            state      <= FILL;
                            mem_rd_req <= 1'b1;
                            mem_addr   <= {tag_q, idx_q};
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        mem_rd_req                <= 1'b0;
                        valid_arr[idx_q][way_q]   <= 1'b1;
                        dirty_arr[idx_q][way_q]   <= 1'b0;
                        tag_arr[idx_q][way_q]     <= tag_q;
                        data_arr[idx_q][way_q]    <= mem_rdata;
                        state                     <= RESP;
                    end
                end
                RESP: begin
                    cpu_ready <= 1'b1;
                    hit       <= hit_q;
                    cpu_rdata <= write_q ? wdata_q : data_arr[idx_q][way_q];
                    if (write_q) begin
                        valid_arr[idx_q][way_q] <= 1'b1;
                        dirty_arr[idx_q][way_q] <= 1'b1;
                        tag_arr[idx_q][way_q]   <= tag_q;
                        data_arr[idx_q][way_q]  <= wdata_q;
                    end
                    // Ages within a set always form a permutation of 0..NUM_WAYS-1.
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        if (AGE_W'(w) == way_q) begin
                            age_arr[idx_q][w] <= '0;
                        end else if (age_arr[idx_q][w] < age_arr[idx_q][way_q]) begin
                            age_arr[idx_q][w] <= age_arr[idx_q][w] + 1'b1;
                        end
                    end
`ifdef CACHE_STATS_EN
                    if (hit_q) begin
                        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                    end else begin
                        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                    end
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_conj_ass_nvias.sv
// Self-checking bench for cache_conj_ass_nvias: directed scenarios plus randomized traffic
// compared against a recency-list cache model and a memory image.
module tb_cache_conj_ass_nvias;

  localparam int NS    = 2;
  localparam int NW    = 4;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int MEM_N = 1 << AW;

  logic          clock;
  logic          reset_n;
  logic          cpu_req;
  logic          cpu_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          hit;
  logic          mem_rd_req;
  logic          mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [1:0]    state_dbg;
`ifdef CACHE_STATS_EN
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;
`endif

  cache_conj_ass_nvias #(.NUM_SETS(NS), .NUM_WAYS(NW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .hit        (hit),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
`ifdef CACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .state_dbg  (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory seen by the DUT, and the memory the model expects.
  logic [DW-1:0] mem_img [MEM_N];
  logic [DW-1:0] ref_mem [MEM_N];

  // Model: each set holds a recency list, index 0 = most recently used.
  int            m_cnt   [NS];
  int            m_tag   [NS][NW];
  logic [DW-1:0] m_data  [NS][NW];
  logic          m_dirty [NS][NW];
  int            m_hits;
  int            m_misses;

  logic          e_hit, e_wb, e_rd;
  logic [AW-1:0] e_wb_addr;
  logic [DW-1:0] e_wb_data, e_rdata;

  int            o_ready_cnt, o_wb_cnt, o_rd_cnt, o_latency;
  logic          o_hit, o_stable, o_both, o_order_ok, o_timeout;
  logic [DW-1:0] o_rdata, o_wb_data;
  logic [AW-1:0] o_wb_addr, o_rd_addr;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic model_reset();
    for (int s = 0; s < NS; s++) m_cnt[s] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int s, t, pos;
    logic [DW-1:0] ln_data;
    logic          ln_dirty;
    s = int'(addr) % NS;
    t = int'(addr) / NS;
    pos = -1;
    for (int k = 0; k < m_cnt[s]; k++) if (m_tag[s][k] == t) pos = k;
    e_hit = (pos >= 0); e_wb = 1'b0; e_rd = 1'b0;
    e_wb_addr = '0; e_wb_data = '0; e_rdata = '0;
    if (pos >= 0) begin
      ln_data  = m_data[s][pos];
      ln_dirty = m_dirty[s][pos];
      if (wr) begin ln_data = wd; ln_dirty = 1'b1; end
      e_rdata = ln_data;
      for (int k = pos; k > 0; k--) begin
        m_tag[s][k] = m_tag[s][k-1]; m_data[s][k] = m_data[s][k-1]; m_dirty[s][k] = m_dirty[s][k-1];
      end
      m_hits++;
    end else begin
      if (m_cnt[s] == NW) begin
        if (m_dirty[s][NW-1]) begin
          e_wb      = 1'b1;
          e_wb_addr = AW'(m_tag[s][NW-1] * NS + s);
          e_wb_data = m_data[s][NW-1];
          ref_mem[e_wb_addr] = e_wb_data;
        end
        m_cnt[s]--;
      end
      if (wr) begin
        ln_data = wd; ln_dirty = 1'b1;
      end else begin
        e_rd = 1'b1; ln_data = ref_mem[addr]; ln_dirty = 1'b0; e_rdata = ln_data;
      end
      for (int k = m_cnt[s]; k > 0; k--) begin
        m_tag[s][k] = m_tag[s][k-1]; m_data[s][k] = m_data[s][k-1]; m_dirty[s][k] = m_dirty[s][k-1];
      end
      m_cnt[s]++;
      m_misses++;
    end
    m_tag[s][0] = t; m_data[s][0] = ln_data; m_dirty[s][0] = ln_dirty;
  endtask

  task automatic apply_reset();
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Drives one CPU access and plays the memory side with random ack delays.
  task automatic run_access(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input int max_dly);
    int            cycles, d;
    logic          done, is_wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wdat;
    o_ready_cnt = 0; o_wb_cnt = 0; o_rd_cnt = 0; o_latency = 0;
    o_hit = 1'b0; o_stable = 1'b1; o_both = 1'b0; o_order_ok = 1'b1; o_timeout = 1'b0;
    o_rdata = '0; o_wb_data = '0; o_wb_addr = '0; o_rd_addr = '0;
    @(negedge clock);
    cpu_req = 1'b1; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clock);
    cpu_req = 1'b0; cpu_write = 1'($urandom); cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
    cycles = 1;
    done   = 1'b0;
    while (!done && cycles < 200) begin
      if (mem_wr_req && mem_rd_req) o_both = 1'b1;
      if (cpu_ready) begin
        o_ready_cnt++; o_hit = hit; o_rdata = cpu_rdata; o_latency = cycles; done = 1'b1;
      end else if (mem_wr_req || mem_rd_req) begin
        is_wr = mem_wr_req; a = mem_addr; wdat = mem_wdata;
        if (is_wr) begin
          o_wb_cnt++; o_wb_addr = a; o_wb_data = wdat;
          if (o_rd_cnt != 0) o_order_ok = 1'b0;
        end else begin
          o_rd_cnt++; o_rd_addr = a;
        end
        d = $urandom_range(max_dly, 0);
        repeat (d) begin
          @(negedge clock); cycles++;
          if (mem_addr !== a) o_stable = 1'b0;
          if (is_wr && (mem_wdata !== wdat || !mem_wr_req)) o_stable = 1'b0;
          if (!is_wr && !mem_rd_req) o_stable = 1'b0;
          if (cpu_ready) o_ready_cnt++;
        end
        mem_ack = 1'b1;
        if (!is_wr) mem_rdata = mem_img[a];
        @(negedge clock); cycles++;
        mem_ack = 1'b0; mem_rdata = DW'($urandom);
        if (is_wr) mem_img[a] = wdat;
        if (is_wr ? mem_wr_req : mem_rd_req) o_stable = 1'b0;
      end else begin
        @(negedge clock); cycles++;
      end
    end
    if (!done) o_timeout = 1'b1;
    else begin
      @(negedge clock);
      if (cpu_ready) o_ready_cnt++;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cpu_ready, hit, mem_rd_req, mem_wr_req} !== 4'b0 || cpu_rdata !== '0 ||
        mem_addr !== '0 || mem_wdata !== '0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b hit=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h st=%0d required all zero",
               cpu_ready, hit, mem_rd_req, mem_wr_req, cpu_rdata, mem_addr, mem_wdata, state_dbg);
    end
    apply_reset();
  endtask

  task automatic test_read_miss();
    model_access(1'b0, 5'd5, '0);
    run_access(1'b0, 5'd5, '0, 4);
    n_checks++;
    if (o_timeout || o_ready_cnt != 1) begin
      n_fail++;
      $display("FAIL t1_ready: got %0d pulses timeout=%b required 1 pulse", o_ready_cnt, o_timeout);
    end
    n_checks++;
    if (o_rd_cnt != 1 || o_rd_addr !== 5'd5 || o_wb_cnt != 0) begin
      n_fail++;
      $display("FAIL t1_mem_req: got rd=%0d addr=%h wb=%0d required rd=1 addr=05 wb=0", o_rd_cnt, o_rd_addr, o_wb_cnt);
    end
    n_checks++;
    if (o_hit !== 1'b0 || o_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL t1_data: got hit=%b rdata=%h required hit=0 rdata=a5", o_hit, o_rdata);
    end
  endtask

  task automatic test_read_hit();
    model_access(1'b0, 5'd5, '0);
    run_access(1'b0, 5'd5, '0, 4);
    n_checks++;
    if (o_rd_cnt != 0 || o_wb_cnt != 0) begin
      n_fail++;
      $display("FAIL t2_no_mem: got rd=%0d wb=%0d required 0 0", o_rd_cnt, o_wb_cnt);
    end
    n_checks++;
    if (o_latency != 2 || o_ready_cnt != 1) begin
      n_fail++;
      $display("FAIL t2_latency: got %0d cycles %0d pulses required 2 cycles 1 pulse", o_latency, o_ready_cnt);
    end
    n_checks++;
    if (o_hit !== 1'b1 || o_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL t2_data: got hit=%b rdata=%h required hit=1 rdata=a5", o_hit, o_rdata);
    end
`ifdef CACHE_STATS_EN
    n_checks++;
    if (hit_count !== 16'd1 || miss_count !== 16'd1) begin
      n_fail++;
      $display("FAIL t6_stats: got hits=%0d misses=%0d required 1 1", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int cycles;
    model_access(1'b0, 5'd5, '0);
    model_access(1'b0, 5'd5, '0);
    @(negedge clock);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 5'd5;
    @(negedge clock);
    cpu_req = 1'b0;
    cycles = 1;
    while (!cpu_ready && cycles < 10) begin @(negedge clock); cycles++; end
    n_checks++;
    if (!cpu_ready || cycles != 2) begin
      n_fail++;
      $display("FAIL b2b_first: got ready=%b after %0d cycles required ready after 2", cpu_ready, cycles);
    end
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 5'd5;
    @(negedge clock);
    cpu_req = 1'b0;
    n_checks++;
    if (cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got ready=%b required 0", cpu_ready);
    end
    @(negedge clock);
    n_checks++;
    if (cpu_ready !== 1'b1 || hit !== 1'b1 || cpu_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL b2b_second: got ready=%b hit=%b rdata=%h required 1 1 a5", cpu_ready, hit, cpu_rdata);
    end
    @(negedge clock);
  endtask

  task automatic test_write_back();
    logic [AW-1:0] fills [3] = '{5'd7, 5'd9, 5'd11};
    model_access(1'b1, 5'd5, 8'h3C);
    run_access(1'b1, 5'd5, 8'h3C, 3);
    n_checks++;
    if (o_hit !== 1'b1 || o_wb_cnt != 0 || o_rd_cnt != 0) begin
      n_fail++;
      $display("FAIL t3_write_hit: got hit=%b wb=%0d rd=%0d required 1 0 0", o_hit, o_wb_cnt, o_rd_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      model_access(1'b0, fills[i], '0);
      run_access(1'b0, fills[i], '0, 3);
      n_checks++;
      if (o_hit !== 1'b0 || o_rd_addr !== fills[i] || o_rdata !== e_rdata) begin
        n_fail++;
        $display("FAIL t3_fill: got hit=%b addr=%h rdata=%h required 0 %h %h", o_hit, o_rd_addr, o_rdata, fills[i], e_rdata);
      end
    end
    model_access(1'b0, 5'd13, '0);
    run_access(1'b0, 5'd13, '0, 5);
    n_checks++;
    if (o_wb_cnt != 1 || o_wb_addr !== 5'd5 || o_wb_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL t3_victim: got wb=%0d addr=%h data=%h required 1 05 3c", o_wb_cnt, o_wb_addr, o_wb_data);
    end
    n_checks++;
    if (o_rd_cnt != 1 || o_rd_addr !== 5'd13 || !o_order_ok || o_both || o_rdata !== e_rdata) begin
      n_fail++;
      $display("FAIL t3_refill: got rd=%0d addr=%h order=%b rdata=%h required 1 0d 1 %h",
               o_rd_cnt, o_rd_addr, o_order_ok, o_rdata, e_rdata);
    end
  endtask

  task automatic test_lru_order();
    logic [AW-1:0] seq  [7] = '{5'd0, 5'd2, 5'd4, 5'd6, 5'd0, 5'd8, 5'd2};
    logic          want [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      model_access(1'b0, seq[i], '0);
      run_access(1'b0, seq[i], '0, 2);
      n_checks++;
      if (o_hit !== want[i] || o_hit !== e_hit || o_wb_cnt != 0) begin
        n_fail++;
        $display("FAIL t4_lru step %0d: got hit=%b wb=%0d required hit=%b wb=0", i, o_hit, o_wb_cnt, want[i]);
      end
    end
    model_access(1'b0, 5'd0, '0);
    run_access(1'b0, 5'd0, '0, 2);
    n_checks++;
    if (o_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_mru_kept: got hit=%b required 1", o_hit);
    end
  endtask

  task automatic test_ack_ignored();
    @(negedge clock);
    mem_ack = 1'b1; mem_rdata = DW'($urandom);
    repeat (2) @(negedge clock);
    mem_ack = 1'b0;
    n_checks++;
    if (mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0 || state_dbg !== 2'd0 || cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ack: got rd=%b wr=%b st=%0d rdy=%b required 0 0 0 0", mem_rd_req, mem_wr_req, state_dbg, cpu_ready);
    end
    model_access(1'b0, 5'd0, '0);
    run_access(1'b0, 5'd0, '0, 2);
    n_checks++;
    if (o_hit !== 1'b1 || o_rdata !== e_rdata || o_ready_cnt != 1) begin
      n_fail++;
      $display("FAIL stray_ack_access: got hit=%b rdata=%h pulses=%0d required 1 %h 1", o_hit, o_rdata, o_ready_cnt, e_rdata);
    end
  endtask

  task automatic test_random();
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    for (int i = 0; i < 300; i++) begin
      wr   = 1'($urandom_range(1, 0));
      addr = AW'($urandom_range(MEM_N - 1, 0));
      wd   = DW'($urandom);
      model_access(wr, addr, wd);
      run_access(wr, addr, wd, 10);
      n_checks++;
      if (o_timeout || o_ready_cnt != 1) begin
        n_fail++;
        $display("FAIL rand_ready #%0d: got %0d pulses timeout=%b required 1", i, o_ready_cnt, o_timeout);
      end
      n_checks++;
      if (o_hit !== e_hit) begin
        n_fail++;
        $display("FAIL rand_hit #%0d addr=%h: got %b required %b", i, addr, o_hit, e_hit);
      end
      n_checks++;
      if (o_wb_cnt != int'(e_wb) || (e_wb && (o_wb_addr !== e_wb_addr || o_wb_data !== e_wb_data))) begin
        n_fail++;
        $display("FAIL rand_wb #%0d: got n=%0d addr=%h data=%h required n=%0d addr=%h data=%h",
                 i, o_wb_cnt, o_wb_addr, o_wb_data, e_wb, e_wb_addr, e_wb_data);
      end
      n_checks++;
      if (o_rd_cnt != int'(e_rd) || (e_rd && o_rd_addr !== addr)) begin
        n_fail++;
        $display("FAIL rand_rd #%0d: got n=%0d addr=%h required n=%0d addr=%h", i, o_rd_cnt, o_rd_addr, e_rd, addr);
      end
      n_checks++;
      if (!o_stable || o_both || !o_order_ok) begin
        n_fail++;
        $display("FAIL rand_handshake #%0d: got stable=%b both=%b order=%b required 1 0 1", i, o_stable, o_both, o_order_ok);
      end
      if (!wr) begin
        n_checks++;
        if (o_rdata !== e_rdata) begin
          n_fail++;
          $display("FAIL rand_rdata #%0d addr=%h: got %h required %h", i, addr, o_rdata, e_rdata);
        end
      end
      if (e_hit) begin
        n_checks++;
        if (o_latency != 2) begin
          n_fail++;
          $display("FAIL rand_hit_latency #%0d: got %0d required 2", i, o_latency);
        end
      end
    end
`ifdef CACHE_STATS_EN
    n_checks++;
    if (hit_count !== 16'(m_hits) || miss_count !== 16'(m_misses)) begin
      n_fail++;
      $display("FAIL rand_stats: got hits=%0d misses=%0d required %0d %0d", hit_count, miss_count, m_hits, m_misses);
    end
`endif
  endtask

  task automatic test_reset_mid_fill();
    int cycles, pulses;
    apply_reset();
    @(negedge clock);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 5'd3;
    @(negedge clock);
    cpu_req = 1'b0;
    cycles = 0;
    while (!mem_rd_req && cycles < 10) begin @(negedge clock); cycles++; end
    n_checks++;
    if (mem_rd_req !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_fill_start: got rd_req=%b required 1", mem_rd_req);
    end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (mem_rd_req !== 1'b0 || cpu_ready !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL t5_reset_drop: got rd_req=%b rdy=%b st=%0d required 0 0 0", mem_rd_req, cpu_ready, state_dbg);
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    pulses = 0;
    repeat (5) begin
      @(negedge clock);
      if (cpu_ready || mem_rd_req) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL t5_no_ready: got %0d active cycles required 0", pulses);
    end
    model_access(1'b0, 5'd3, '0);
    run_access(1'b0, 5'd3, '0, 3);
    n_checks++;
    if (o_hit !== 1'b0 || o_rd_cnt != 1 || o_rdata !== e_rdata) begin
      n_fail++;
      $display("FAIL t5_reread: got hit=%b rd=%0d rdata=%h required 0 1 %h", o_hit, o_rd_cnt, o_rdata, e_rdata);
    end
  endtask

  initial begin
    reset_n = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < MEM_N; i++) begin
      mem_img[i] = DW'($urandom);
      ref_mem[i] = mem_img[i];
    end
    mem_img[5] = 8'hA5;
    ref_mem[5] = 8'hA5;
    model_reset();
    test_reset();
    test_read_miss();
    test_read_hit();
    test_back_to_back();
    test_write_back();
    test_lru_order();
    test_ack_ignored();
    test_random();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
